dff_arbiter: RTL and testbench

Round-robin write arbiter for a shared W-bit enable register: N requesters compete to load the register, and one requester wins per clock. The block owns the register itself (clear, enable, data-in), so requesters never drive it directly. It sits between the lab's requester modules and the storage element, and replaces ad-hoc muxing of `en`/`d`.

---
 rtl/dff_arbiter_if.sv | 38 +++
 rtl/dff_arbiter.sv | 147 ++++++++++++++
 tb/tb_dff_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dff_arbiter_if.sv
// Requester-side bundle for dff_arbiter: requests, data, grant and register view.
// The lock port exists only when DFF_ARB_LOCK_EN is defined.
interface dff_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
`ifdef DFF_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           wr_valid;
  logic [IW-1:0]  owner;

`ifdef DFF_ARB_LOCK_EN
  modport master (
    output req, wdata, lock,
    input  gnt, q, wr_valid, owner
  );
  modport slave (
    input  req, wdata, lock,
    output gnt, q, wr_valid, owner
  );
`else
  modport master (
    output req, wdata,
    input  gnt, q, wr_valid, owner
  );
  modport slave (
    input  req, wdata,
    output gnt, q, wr_valid, owner
  );
`endif
endinterface

// File: rtl/dff_arbiter.sv
// Round-robin write arbiter owning a shared W-bit register.
// Define DFF_ARB_LOCK_EN to enable lock bursts of up to LOCK_MAX grants.
module dff_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int LOCK_MAX = 4
) (
  input logic          clk,
  input logic          clr_n,
  dff_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] owner_r;
  logic [IW-1:0] win;
  logic [N-1:0]  gnt_r;
  logic [N-1:0]  gnt_nxt;
  logic [N-1:0]  mreq;
  logic [W-1:0]  q_r;
  logic [W-1:0]  q_nxt;
  logic          wr_r;
  logic          hit;
  logic          found;
  logic          relock;
  int            sj;

`ifdef DFF_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    relock = 1'b0;
    if (state == GRANT &&
        bus.req[owner_r] &&
        bus.lock[owner_r] &&
        cnt < CW'(LOCK_MAX))
      relock = 1'b1;
  end
`else
  assign relock = 1'b0;
`endif

  // The grant holder is masked for one evaluation unless it re-locks.
  always_comb begin
    mreq = bus.req;
    if (state == GRANT && !relock)
      mreq[owner_r] = 1'b0;
  end

  always_comb begin
    win   = ptr;
    found = 1'b0;
    sj    = 0;
    for (int k = 0; k < N; k++) begin
      sj = int'(ptr) + k;
      if (sj >= N)
        sj = sj - N;
      if (!found && mreq[sj]) begin
        found = 1'b1;
        win   = IW'(sj);
      end
    end
    if (relock)
      win = owner_r;
  end

  assign hit = found | relock;

  always_ff @(posedge clk) begin
    if (!clr_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = hit ? GRANT : IDLE;
      GRANT:   state_nxt = hit ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt = '0;
    q_nxt   = q_r;
    ptr_nxt = ptr;
    if (hit) begin
      gnt_nxt = {{(N-1){1'b0}}, 1'b1} << win;
      q_nxt   = bus.wdata[int'(win)*W +: W];
      if (!relock)
        ptr_nxt = (win == IW'(N-1)) ? '0 : win + 1'b1;
    end
  end

`ifdef DFF_ARB_LOCK_EN
  always_comb begin
    cnt_nxt = '0;
    if (relock)
      cnt_nxt = cnt + 1'b1;
    else if (hit)
      cnt_nxt = CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      gnt_r   <= '0;
      q_r     <= '0;
      wr_r    <= 1'b0;
      owner_r <= '0;
      ptr     <= '0;
    end else begin
      gnt_r <= gnt_nxt;
      q_r   <= q_nxt;
      wr_r  <= hit;
      ptr   <= ptr_nxt;
      if (hit)
        owner_r <= win;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.q        = q_r;
  assign bus.wr_valid = wr_r;
  assign bus.owner    = owner_r;
endmodule

// File: tb/tb_dff_arbiter.sv
// Directed and randomized bench for dff_arbiter against a distance-based model.
// Lock steps run only when DFF_ARB_LOCK_EN is defined.
module tb_dff_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  dff_arbiter_if #(.N(N), .W(W)) bus ();

  dff_arbiter #(
    .N(N), .W(W), .LOCK_MAX(LM)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int           m_ptr;
  int           m_last;
  int           m_cnt;
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  logic [1:0]   m_owner;

  // Winner = eligible requester closest to ptr going upward (mod N).
  task automatic model_edge();
    int best, bestd, d;
    bit relock;
    if (!clr_n) begin
      m_ptr = 0; m_last = -1; m_cnt = 0;
      m_q = '0; m_gnt = '0; m_owner = '0;
      return;
    end
    best = -1; bestd = N; relock = 0;
`ifdef DFF_ARB_LOCK_EN
    if (m_last >= 0 && bus.req[m_last] &&
        bus.lock[m_last] && m_cnt < LM)
      relock = 1;
`endif
    if (relock) best = m_last;
    else
      for (int i = 0; i < N; i++)
        if (bus.req[i] && i != m_last) begin
          d = (i - m_ptr + N) % N;
          if (d < bestd) begin
            bestd = d; best = i;
          end
        end
    if (best < 0) begin
      m_gnt = '0; m_last = -1; m_cnt = 0;
    end else begin
      m_gnt   = N'(1) << best;
      m_q     = bus.wdata[best*W +: W];
      m_owner = 2'(best);
      if (relock) m_cnt++;
      else begin
        m_ptr = (best + 1) % N;
        m_cnt = 1;
      end
      m_last = best;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_out(
    input string        tag,
    input logic [N-1:0] g,
    input logic [W-1:0] qv,
    input logic         wv,
    input logic [1:0]   ov
  );
    checks++;
    assert (bus.gnt === g) else begin
      errors++;
      $error("FAIL %s gnt got %b exp %b", tag, bus.gnt, g);
    end
    checks++;
    assert (bus.q === qv) else begin
      errors++;
      $error("FAIL %s q got %h exp %h", tag, bus.q, qv);
    end
    checks++;
    assert (bus.wr_valid === wv) else begin
      errors++;
      $error("FAIL %s wr_valid got %b exp %b",
             tag, bus.wr_valid, wv);
    end
    checks++;
    assert (bus.owner === ov) else begin
      errors++;
      $error("FAIL %s owner got %0d exp %0d",
             tag, bus.owner, ov);
    end
  endtask

  initial begin
    clr_n     = 1'b0;
    bus.req   = 4'b1111;
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef DFF_ARB_LOCK_EN
    bus.lock  = '0;
`endif
    tick(); tick();
    expect_out("reset", 4'b0000, 8'h00, 1'b0, 2'd0);

    clr_n = 1'b1;
    tick();
    expect_out("full0", 4'b0001, 8'h10, 1'b1, 2'd0);
    bus.req = 4'b1110; tick();
    expect_out("full1", 4'b0010, 8'h11, 1'b1, 2'd1);
    bus.req = 4'b1100; tick();
    expect_out("full2", 4'b0100, 8'h12, 1'b1, 2'd2);
    bus.req = 4'b1000; tick();
    expect_out("full3", 4'b1000, 8'h13, 1'b1, 2'd3);
    bus.req = 4'b0000; tick();
    expect_out("idle0", 4'b0000, 8'h13, 1'b0, 2'd3);

    bus.req = 4'b0010;
    bus.wdata[1*W +: W] = 8'hA5;
    tick();
    expect_out("single", 4'b0010, 8'hA5, 1'b1, 2'd1);
    bus.req = 4'b0000; tick();
    expect_out("single_hold", 4'b0000, 8'hA5, 1'b0, 2'd1);

    bus.req = 4'b0100; tick();
    expect_out("wrap_pre", 4'b0100, 8'h12, 1'b1, 2'd2);
    bus.req = 4'b0000; tick();
    bus.req = 4'b0101; tick();
    expect_out("wrap0", 4'b0001, 8'h10, 1'b1, 2'd0);
    bus.req = 4'b0100; tick();
    expect_out("wrap1", 4'b0100, 8'h12, 1'b1, 2'd2);
    bus.req = 4'b0000; tick();

    bus.req = 4'b0100; tick();
    expect_out("mid_pre", 4'b0100, 8'h12, 1'b1, 2'd2);
    clr_n = 1'b0; bus.req = 4'b1011; tick();
    expect_out("mid_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    clr_n = 1'b1; tick();
    expect_out("mid_rel", 4'b0001, 8'h10, 1'b1, 2'd0);
    bus.req = 4'b0000; tick();

`ifdef DFF_ARB_LOCK_EN
    bus.req  = 4'b1010;
    bus.lock = 4'b0010;
    for (int k = 0; k < LM; k++) begin
      bus.wdata[1*W +: W] = 8'h20 + 8'(k);
      tick();
      expect_out("lock_burst", 4'b0010,
                 8'h20 + 8'(k), 1'b1, 2'd1);
    end
    tick();
    expect_out("lock_end", 4'b1000, 8'h13, 1'b1, 2'd3);
    bus.req = 4'b0000; bus.lock = 4'b0000; tick();
`endif

    clr_n = 1'b0; tick();
    clr_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus.req   = 4'($urandom);
      bus.wdata = $urandom;
`ifdef DFF_ARB_LOCK_EN
      bus.lock  = 4'($urandom | $urandom);
`endif
      clr_n = ($urandom_range(0, 24) != 0);
      tick();
      expect_out("rnd", m_gnt, m_q, |m_gnt, m_owner);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
